// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int WAIT_MAX_DEFAULT = 16;
    localparam int WAIT_CNT_SAT     = 255;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, data port and shared memory port of the arbiter, bundled for connection.
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [31:0]           d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  bus_err;

    // Arbiter side: accepts core requests and drives the memory
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating stall counter; flags the stalled cycle that brings the count up to WAIT_MAX.
module mem_wait_timer
    import riscv_mem_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [7:0] CNT_SAT = 8'(WAIT_CNT_SAT);
    localparam logic [8:0] LIMIT   = 9'(WAIT_MAX);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && count_reg != CNT_SAT) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Looks one count ahead so the transaction ends right after the WAIT_MAX-th stall
    assign expired = (LIMIT != 9'd0) && count_en && (({1'b0, count_reg} + 9'd1) == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
module mem_bus_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_MAX   = WAIT_MAX_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    arb_state_t state_reg;
    owner_t     last_owner_reg;
    logic       grant_if;
    logic       grant_d;
    logic       timer_clear;
    logic       timer_en;
    logic       expired;

    // On a tie the side that did not own the bus last time wins
    always_comb begin
        grant_d  = bus.d_req && (!bus.if_req || last_owner_reg == OWN_IF);
        grant_if = bus.if_req && !grant_d;
    end

    assign timer_clear = (state_reg == IDLE) && (bus.if_req || bus.d_req);
    assign timer_en    = (state_reg != IDLE) && !bus.mem_ready;

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (timer_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWN_IF;
            bus.if_gnt     <= 1'b0;
            bus.if_rvalid  <= 1'b0;
            bus.if_rdata   <= ZERO_DATA;
            bus.d_gnt      <= 1'b0;
            bus.d_rvalid   <= 1'b0;
            bus.d_rdata    <= ZERO_DATA;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= ZERO_DATA;
            bus.bus_err    <= 1'b0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.bus_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg      <= D_BUSY;
                        last_owner_reg <= OWN_D;
                        bus.d_gnt      <= 1'b1;
                        bus.mem_req    <= 1'b1;
                        bus.mem_we     <= bus.d_we;
                        bus.mem_addr   <= bus.d_addr;
                        bus.mem_wdata  <= bus.d_wdata;
                    end else if (grant_if) begin
                        state_reg      <= IF_BUSY;
                        last_owner_reg <= OWN_IF;
                        bus.if_gnt     <= 1'b1;
                        bus.mem_req    <= 1'b1;
                        bus.mem_we     <= 1'b0;
                        bus.mem_addr   <= bus.if_addr;
                        bus.mem_wdata  <= ZERO_DATA;
                    end
                end
                IF_BUSY, D_BUSY: begin
                    // A ready in the expiry cycle completes normally: expired is gated by !mem_ready
                    if (bus.mem_ready || expired) begin
                        state_reg   <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= !bus.mem_ready;
                        if (state_reg == IF_BUSY) begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_ready ? bus.mem_rdata : ZERO_DATA;
                        end else begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_rdata  <= (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : ZERO_DATA;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner sequences, random run vs. model.
module tb_mem_bus_arbiter;

    localparam int DW = 32;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_bus_arbiter #(
        .DATA_WIDTH (DW),
        .WAIT_MAX   (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          if_r;
        bit          d_r;
        bit          we;
        logic [31:0] if_a;
        logic [31:0] d_a;
        logic [31:0] wd;
        int          stalls;
        logic [31:0] mem_rd;
        bit          exp_d;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea, ewd;
        bit ewe;
        int n_req;
        bus.if_req    = v.if_r;
        bus.if_addr   = v.if_a;
        bus.d_req     = v.d_r;
        bus.d_we      = v.we;
        bus.d_addr    = v.d_a;
        bus.d_wdata   = v.wd;
        bus.mem_ready = 1'b0;
        tick();
        check("v_if_gnt", bus.if_gnt, !v.exp_d);
        check("v_d_gnt", bus.d_gnt, v.exp_d);
        if (v.exp_d) bus.d_req = 1'b0;
        else bus.if_req = 1'b0;
        ea    = v.exp_d ? v.d_a : v.if_a;
        ewe   = v.exp_d && v.we;
        ewd   = v.exp_d ? v.wd : 32'h0;
        n_req = (v.stalls < W) ? v.stalls + 1 : W;
        for (int i = 0; i < n_req; i++) begin
            check("v_mem_req", bus.mem_req, 1'b1);
            check("v_mem_addr", bus.mem_addr, ea);
            check("v_mem_we", bus.mem_we, ewe);
            check("v_mem_wdata", bus.mem_wdata, ewd);
            check("v_rvalid_busy", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
            if (i > 0) check("v_gnt_busy", {bus.if_gnt, bus.d_gnt}, 2'b00);
            bus.mem_ready = (i == v.stalls);
            bus.mem_rdata = (i == v.stalls) ? v.mem_rd : $urandom();
            tick();
        end
        bus.mem_ready = 1'b0;
        check("v_mem_req_end", bus.mem_req, 1'b0);
        check("v_if_rvalid", bus.if_rvalid, !v.exp_d);
        check("v_d_rvalid", bus.d_rvalid, v.exp_d);
        check("v_bus_err", bus.bus_err, v.exp_err);
        check("v_rdata", v.exp_d ? bus.d_rdata : bus.if_rdata, v.exp_rd);
        $display("vec %0d: owner=%s addr=%h stalls=%0d err=%0b rdata=%h", idx,
                 v.exp_d ? "D" : "IF", ea, v.stalls, v.exp_err, v.exp_rd);
    endtask

    // Random-phase model state: a transaction granted at cycle g ends (rvalid) at cycle e
    int g, e, k, ntx;
    bit busy, own_d, last_d, m_err, if_pend, d_pend, m_we;
    logic [31:0] m_addr, m_wdata, cap;
    bit e_ig, e_dg, e_iv, e_dv, e_err;
    logic [31:0] e_ird, e_drd;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h3000, 32'h0,        0, 32'h11111111, 1'b1, 1'b0, 32'h11111111};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h3000, 32'h0,        1, 32'h22222222, 1'b0, 1'b0, 32'h22222222};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h2000, 32'hDEADBEEF, 3, 32'h33333333, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,    32'h0,        0, 32'h00500093, 1'b0, 1'b0, 32'h00500093};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h40,   32'h5A5A5A5A, 9, 32'h44444444, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h0,    32'h0,        9, 32'h55555555, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h80,   32'h0,        3, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'h90,   32'h0,        2, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0BADC0DE};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'hA0,   32'h12345678, 9, 32'h66666666, 1'b1, 1'b1, 32'h0};

        // Reset state, including a request raised while reset is held
        reset = 1'b0;
        idle_inputs();
        tick();
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        tick();
        check("rst_gnt", {bus.if_gnt, bus.d_gnt}, 2'b00);
        check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid, bus.bus_err}, 3'b000);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
        $display("reset: outputs checked while held");
        do_reset();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        idle_inputs();
        tick();

        // Fetch request arriving while data owns the bus waits for the next idle cycle
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h500;
        tick();
        check("busy_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req   = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h204;
        for (int i = 0; i < 3; i++) begin
            check("busy_if_held", {bus.if_gnt, bus.if_rvalid, bus.mem_req}, 3'b001);
            bus.mem_ready = (i == 2);
            bus.mem_rdata = 32'hA5A5A5A5;
            tick();
        end
        bus.mem_ready = 1'b0;
        check("busy_d_rvalid", bus.d_rvalid, 1'b1);
        check("busy_no_overlap", bus.if_gnt, 1'b0);
        tick();
        check("busy_if_gnt", {bus.if_gnt, bus.d_rvalid}, 2'b10);
        check("busy_if_addr", bus.mem_addr, 32'h204);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000006F;
        tick();
        bus.mem_ready = 1'b0;
        check("busy_if_rvalid", bus.if_rvalid, 1'b1);
        check("busy_if_rdata", bus.if_rdata, 32'h0000006F);
        $display("seq busy: data read 0x500 then fetch 0x204");

        // Reset cuts an in-flight data access; the still-held request is granted afresh
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h600;
        tick();
        check("rmid_d_gnt", bus.d_gnt, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        check("rmid_mem_req", bus.mem_req, 1'b0);
        check("rmid_addr", bus.mem_addr, 32'h0);
        check("rmid_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rmid_no_rvalid", {bus.d_rvalid, bus.d_gnt}, 2'b00);
        end
        reset = 1'b1;
        tick();
        check("rmid_regrant", {bus.d_gnt, bus.mem_req}, 2'b11);
        check("rmid_regrant_addr", bus.mem_addr, 32'h600);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00000077;
        tick();
        bus.mem_ready = 1'b0;
        check("rmid_d_rvalid", bus.d_rvalid, 1'b1);
        check("rmid_d_rdata", bus.d_rdata, 32'h00000077);
        $display("seq reset-mid: data read 0x600 cut and regranted");

        // Random run against a transaction-level model
        do_reset();
        g = -100; e = 0; k = 0; ntx = 0;
        own_d = 1'b0; last_d = 1'b0; m_err = 1'b0; if_pend = 1'b0; d_pend = 1'b0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; cap = '0;
        e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
        e_ird = '0; e_drd = '0;
        for (int t = 0; t < 1500; t++) begin
            tick();
            busy = (t >= g) && (t < e);
            check("r_if_gnt", bus.if_gnt, e_ig);
            check("r_d_gnt", bus.d_gnt, e_dg);
            check("r_if_rvalid", bus.if_rvalid, e_iv);
            check("r_d_rvalid", bus.d_rvalid, e_dv);
            check("r_bus_err", bus.bus_err, e_err);
            check("r_mem_req", bus.mem_req, busy);
            check("r_if_rdata", bus.if_rdata, e_ird);
            check("r_d_rdata", bus.d_rdata, e_drd);
            if (busy) begin
                check("r_mem_addr", bus.mem_addr, m_addr);
                check("r_mem_we", bus.mem_we, m_we);
                check("r_mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (t == g) begin
                if (own_d) d_pend = 1'b0;
                else if_pend = 1'b0;
            end
            if (!if_pend && $urandom_range(0, 99) < 35) begin
                if_pend     = 1'b1;
                bus.if_addr = $urandom();
            end
            if (!d_pend && $urandom_range(0, 99) < 35) begin
                d_pend      = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end
            bus.if_req    = if_pend;
            bus.d_req     = d_pend;
            bus.mem_rdata = $urandom();
            if (busy) bus.mem_ready = (t == g + k);
            else bus.mem_ready = 1'($urandom_range(0, 1));
            if (busy && t == g + k) cap = (own_d && m_we) ? 32'h0 : bus.mem_rdata;

            e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
            if (busy && t + 1 == e) begin
                if (own_d) begin
                    e_dv  = 1'b1;
                    e_drd = m_err ? 32'h0 : cap;
                end else begin
                    e_iv  = 1'b1;
                    e_ird = m_err ? 32'h0 : cap;
                end
                e_err = m_err;
                ntx++;
                $display("rand txn %0d: owner=%s addr=%h we=%0b stalls=%0d err=%0b", ntx,
                         own_d ? "D" : "IF", m_addr, m_we, k, m_err);
            end
            if (!busy && (if_pend || d_pend)) begin
                own_d   = d_pend && (!if_pend || !last_d);
                last_d  = own_d;
                g       = t + 1;
                k       = $urandom_range(0, 6);
                e       = (k < W) ? g + k + 1 : g + W;
                m_err   = (k >= W);
                m_addr  = own_d ? bus.d_addr : bus.if_addr;
                m_we    = own_d && bus.d_we;
                m_wdata = own_d ? bus.d_wdata : 32'h0;
                if (own_d) e_dg = 1'b1;
                else e_ig = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
